trivium_rng: RTL and testbench
==============================

Name: trivium_rng

Overview:
- Keystream PRNG feeding the error-generation controller.
- Produces 96-bit random words on a start/finish handshake: rng_start in, rng_finish pulse plus rng_data out.
- Core is a Trivium stream cipher, unrolled W steps per clock, seeded once by an 80-bit key and an 80-bit IV.
- Sits directly upstream of the support/error-vector generation control and supplies all its entropy (rnd_pool, occupy_lut).

Parameters:
- W, 8, keystream bits produced per clock; legal values 1, 2, 4, 8, 16, 32 (must divide 96 and 1152, and be at most 64).
- WARMUP, 1152, number of Trivium blank rounds after seeding; must be a multiple of W.

Ports:
- clk  input  1  system clock.
- rst_b  input  1  asynchronous active-low reset.
- seed_load  input  1  one-cycle pulse; captures seed_key and seed_iv, then starts warm-up.
- seed_key  input  80  Trivium key K1..K80; K1 = bit 79.
- seed_iv  input  80  Trivium IV IV1..IV80; IV1 = bit 79.
- rng_start  input  1  request for one 96-bit word; a single-cycle pulse is sufficient.
- rng_finish  output  1  one-cycle pulse; rng_data is valid from this cycle onward.
- rng_data  output  96  random word; first keystream bit is in bit 95; held until the next rng_finish.
- seeded  output  1  high once warm-up has completed.
- busy  output  1  high during WARMUP or GEN.

Behaviour:
- Reset (asynchronous, rst_b=0):
  - State clears to 288'b0; FSM goes to UNSEEDED.
  - rng_finish=0, rng_data=0, seeded=0, busy=0, pending=0, counters=0.
- Trivium step, bit-indexed s1..s288:
  - t1=s66^s93; t2=s162^s177; t3=s243^s288; z=t1^t2^t3.
  - t1^=s91&s92^s171; t2^=s175&s176^s264; t3^=s286&s287^s69.
  - Shift: (s1..s93)<=(t3,s1..s92); (s94..s177)<=(t1,s94..s176); (s178..s288)<=(t2,s178..s287).
  - The W steps per clock are combinationally chained. Step 0's z is the earliest bit.
- Load on seed_load:
  - (s1..s93)=(K1..K80,13'b0); (s94..s177)=(IV1..IV80,4'b0); (s178..s288)=(108'b0,3'b111).
- FSM states:
  - UNSEEDED:
    - seed_load -> WARMUP (state loaded, warm counter=0).
    - rng_start -> sets pending.
  - WARMUP:
    - Runs W steps per cycle and discards z.
    - After WARMUP/W cycles -> READY; seeded<=1.
  - READY:
    - rng_start or pending -> GEN; pending<=0; word counter=0.
  - GEN:
    - Each cycle, shifts W bits of z into the word shift register, earliest bit toward bit 95.
    - After 96/W cycles, rng_data<=assembled word and rng_finish=1 for exactly one cycle -> READY.
    - With the defaults, latency from rng_start sampled in READY to rng_finish is 12 cycles (rng_start at cycle 0, rng_finish at cycle 12).
- Request queue:
  - rng_start while busy (WARMUP or GEN), or while UNSEEDED, sets pending (one-deep queue).
  - Further starts while pending=1 are dropped.
  - A start arriving in the same cycle as rng_finish is queued; GEN restarts on the next cycle, so back-to-back words cost 96/W+1 cycles each.
- seed_load priority:
  - seed_load in any state overrides everything: reloads the state, clears the word counter, returns to WARMUP and drops seeded to 0.
  - pending is kept, so a request interrupted mid-GEN is served after warm-up; the partially assembled word is discarded and no rng_finish is issued for it.
- Simultaneous seed_load and rng_start: the load wins and the start is queued.
- rng_data changes only on rng_finish.

Optional Feature:
- Macro RNG_DBG_CNT_EN (deterministic debug mode).
- Defined:
  - rng_data is a 96-bit counter: starts at 1 after reset or seed_load and increments after each delivered word.
  - FSM timing, warm-up and handshake are unchanged, so control logic sees identical latency.
  - The Trivium datapath is still clocked but its z output is unused.
- Undefined: Trivium keystream, as described above.

Test Plan:
- Reset, then seed_load with key=0 and IV=0; wait for seeded -> seeded rises exactly 144 cycles after seed_load (W=8). The first rng_start yields rng_finish 12 cycles later, and rng_data equals keystream bits 0..95 from the team's Trivium C model, bit 0 in rng_data[95].
- Pulse rng_start in the same cycle as rng_finish, 4 consecutive times -> 4 distinct words, rng_finish spacing 13 cycles, concatenation equals keystream bits 0..383.
- rng_start before any seed_load -> no rng_finish until seed_load plus 144 cycles; first rng_finish arrives 13 cycles after seeded rises. A second queued start during GEN is served; a third is dropped.
- seed_load asserted 5 cycles into GEN -> no rng_finish for the aborted word; after re-warm-up the word equals the fresh keystream bits 0..95.
- rst_b low mid-WARMUP, asynchronous to clk -> all outputs zero immediately; no rng_finish until the next seed_load.
- Build with RNG_DBG_CNT_EN, seed, 3 starts -> rng_data = 96'h1, 96'h2, 96'h3, each after 12 cycles.

Source files
------------

// File: rtl/trivium_rng_if.sv
// trivium_rng_if: seeding and word-request handshake between the keystream RNG
// and the error-generation controller that consumes its words.
interface trivium_rng_if;
    logic        seed_load;
    logic [79:0] seed_key;
    logic [79:0] seed_iv;
    logic        rng_start;
    logic        rng_finish;
    logic [95:0] rng_data;
    logic        seeded;
    logic        busy;

    // Consumer side: seeds the generator and requests words
    modport master (
        output seed_load, seed_key, seed_iv, rng_start,
        input  rng_finish, rng_data, seeded, busy
    );

    // Generator side
    modport slave (
        input  seed_load, seed_key, seed_iv, rng_start,
        output rng_finish, rng_data, seeded, busy
    );
endinterface

// File: rtl/trivium_rng.sv
// trivium_rng: Trivium keystream generator delivering 96-bit words on a
// start/finish handshake. W cipher steps are chained per clock.
// Optional build macro RNG_DBG_CNT_EN replaces the delivered word with a
// deterministic counter (1, 2, 3, ...) while keeping all control timing.
//
// Internal state bit s_k (k = 1..288 in cipher notation) lives at s[k-1].

// One Trivium round: consumes a 288-bit state, yields next state and z.
module trivium_step (
    input  logic [287:0] s_in,
    output logic [287:0] s_out,
    output logic         z
);
    logic t1, t2, t3, a1, a2, a3;

    // Output bit and feedback taps of a single round
    always_comb begin
        t1    = s_in[65]  ^ s_in[92];
        t2    = s_in[161] ^ s_in[176];
        t3    = s_in[242] ^ s_in[287];
        z     = t1 ^ t2 ^ t3;
        a1    = t1 ^ (s_in[90]  & s_in[91])  ^ s_in[170];
        a2    = t2 ^ (s_in[174] & s_in[175]) ^ s_in[263];
        a3    = t3 ^ (s_in[285] & s_in[286]) ^ s_in[68];
        // Each of the three registers shifts up by one and takes its feedback at the bottom
        s_out = {s_in[286:177], a2, s_in[175:93], a1, s_in[91:0], a3};
    end
endmodule

module trivium_rng #(
    parameter int W      = 8,
    parameter int WARMUP = 1152
) (
    input  logic         clk,
    input  logic         rst_b,
    trivium_rng_if.slave rng
);
    localparam int WARM_CYC = WARMUP / W;
    localparam int WORD_CYC = 96 / W;
    localparam int CW       = $clog2(WARM_CYC + 1);
    localparam logic [CW-1:0] WARM_LAST = CW'(WARM_CYC - 1);
    localparam logic [CW-1:0] WORD_LAST = CW'(WORD_CYC - 1);

    typedef enum logic [1:0] {
        S_UNSEEDED = 2'd0,
        S_WARMUP   = 2'd1,
        S_READY    = 2'd2,
        S_GEN      = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic            pending, pending_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            seeded_q, seeded_nxt;
    logic            step_en;
    logic            deliver;

    logic [287:0]    s;
    logic [287:0]    load_vec;
    logic [W:0][287:0] chain;
    logic [W-1:0]    zv;
    logic [95:0]     word;
    logic [95:0]     word_nxt;
    logic [95:0]     deliver_word;

    // Cipher rounds chained combinationally; step 0 is the oldest bit, placed at the MSB of zv
    assign chain[0] = s;
    for (genvar i = 0; i < W; i++) begin : g_step
        trivium_step u_step (
            .s_in  (chain[i]),
            .s_out (chain[i+1]),
            .z     (zv[W-1-i])
        );
    end

    // Oldest keystream bits drift toward bit 95 as new chunks enter at the bottom
    assign word_nxt = {word[95-W:0], zv};

    // Seed image: key and IV bit-reversed so K1/IV1 land on s1/s94, s286..s288 set
    always_comb begin
        load_vec = '0;
        for (int j = 0; j < 80; j++) begin
            load_vec[j]      = rng.seed_key[79-j];
            load_vec[93 + j] = rng.seed_iv[79-j];
        end
        load_vec[287:285] = 3'b111;
    end

    // Next-state logic: seed_load overrides everything, otherwise per-state handling
    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        cnt_nxt     = cnt;
        seeded_nxt  = seeded_q;
        step_en     = 1'b0;
        deliver     = 1'b0;
        if (rng.seed_load) begin
            state_nxt  = S_WARMUP;
            cnt_nxt    = '0;
            seeded_nxt = 1'b0;
            // A word cut short by the reload is re-requested after warm-up
            if (rng.rng_start || state == S_GEN)
                pending_nxt = 1'b1;
        end else begin
            case (state)
                S_UNSEEDED: begin
                    if (rng.rng_start)
                        pending_nxt = 1'b1;
                end
                S_WARMUP: begin
                    step_en = 1'b1;
                    if (rng.rng_start)
                        pending_nxt = 1'b1;
                    if (cnt == WARM_LAST) begin
                        state_nxt  = S_READY;
                        cnt_nxt    = '0;
                        seeded_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                S_READY: begin
                    if (rng.rng_start || pending) begin
                        state_nxt   = S_GEN;
                        pending_nxt = 1'b0;
                        cnt_nxt     = '0;
                    end
                end
                S_GEN: begin
                    step_en = 1'b1;
                    if (rng.rng_start)
                        pending_nxt = 1'b1;
                    if (cnt == WORD_LAST) begin
                        deliver   = 1'b1;
                        state_nxt = S_READY;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: state_nxt = S_UNSEEDED;
            endcase
        end
    end

    // Control registers: FSM state, one-deep request queue, shared counter, seeded flag
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state    <= S_UNSEEDED;
            pending  <= 1'b0;
            cnt      <= '0;
            seeded_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            pending  <= pending_nxt;
            cnt      <= cnt_nxt;
            seeded_q <= seeded_nxt;
        end
    end

    // Cipher state and word assembly; the cipher only advances while warming up or generating
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            s    <= '0;
            word <= '0;
        end else if (rng.seed_load) begin
            s    <= load_vec;
            word <= '0;
        end else if (step_en) begin
            s    <= chain[W];
            word <= word_nxt;
        end
    end

`ifdef RNG_DBG_CNT_EN
    logic [95:0] dbg_cnt;

    // Debug word counter: restarts at 1 on reset or reseed, advances per delivered word
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)
            dbg_cnt <= 96'd1;
        else if (rng.seed_load)
            dbg_cnt <= 96'd1;
        else if (deliver)
            dbg_cnt <= dbg_cnt + 96'd1;
    end

    assign deliver_word = dbg_cnt;
`else
    assign deliver_word = word_nxt;
`endif

    // Output word and finish pulse; rng_data only moves when a word is delivered
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            rng.rng_finish <= 1'b0;
            rng.rng_data   <= '0;
        end else begin
            rng.rng_finish <= deliver;
            if (deliver)
                rng.rng_data <= deliver_word;
        end
    end

    assign rng.seeded = seeded_q;
    assign rng.busy   = (state == S_WARMUP) || (state == S_GEN);
endmodule

// File: tb/tb_trivium_rng.sv
// tb_trivium_rng: directed bench for trivium_rng with a bit-level Trivium
// reference model feeding a scoreboard of expected words.
module tb_trivium_rng;
    localparam int WARM = 144;   // warm-up cycles at W=8
    localparam int LAT  = 12;    // start-to-finish cycles at W=8

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    logic [95:0] exp_q[$];
    int          fin_q[$];
    bit          ms [1:288];

    trivium_rng_if rng_if ();

    trivium_rng dut (
        .clk   (clk),
        .rst_b (rst_b),
        .rng   (rng_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp_v);
        total++;
        assert (obs === exp_v)
        else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, obs, exp_v);
        end
    endtask

    // Reference Trivium round in 1-based cipher notation
    function automatic bit mstep();
        bit t1, t2, t3, z;
        t1 = ms[66] ^ ms[93];
        t2 = ms[162] ^ ms[177];
        t3 = ms[243] ^ ms[288];
        z  = t1 ^ t2 ^ t3;
        t1 = t1 ^ (ms[91] & ms[92]) ^ ms[171];
        t2 = t2 ^ (ms[175] & ms[176]) ^ ms[264];
        t3 = t3 ^ (ms[286] & ms[287]) ^ ms[69];
        for (int i = 288; i > 178; i--) ms[i] = ms[i-1];
        ms[178] = t2;
        for (int i = 177; i > 94; i--) ms[i] = ms[i-1];
        ms[94] = t1;
        for (int i = 93; i > 1; i--) ms[i] = ms[i-1];
        ms[1] = t3;
        return z;
    endfunction

    task automatic model_seed(input logic [79:0] k, input logic [79:0] iv);
        for (int i = 1; i <= 288; i++) ms[i] = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            ms[i]      = k[80-i];
            ms[93 + i] = iv[80-i];
        end
        ms[286] = 1'b1;
        ms[287] = 1'b1;
        ms[288] = 1'b1;
        repeat (1152) void'(mstep());
    endtask

    function automatic logic [95:0] next_word();
        logic [95:0] w;
        for (int i = 0; i < 96; i++) w[95-i] = mstep();
        return w;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start(output int e);
        rng_if.rng_start = 1'b1;
        tick();
        rng_if.rng_start = 1'b0;
        e = cyc;
    endtask

    task automatic do_seed(input logic [79:0] k, input logic [79:0] iv, output int e);
        rng_if.seed_key  = k;
        rng_if.seed_iv   = iv;
        rng_if.seed_load = 1'b1;
        tick();
        rng_if.seed_load = 1'b0;
        e = cyc;
        model_seed(k, iv);
    endtask

    task automatic wait_fin(input string tag, input int n_before, output int c);
        int k = 0;
        while (fin_q.size() <= n_before && k < 400) begin
            tick();
            k++;
        end
        chk({tag, "_arrived"}, 96'(fin_q.size() > n_before), 96'd1);
        c = (fin_q.size() > n_before) ? fin_q[n_before] : -1;
    endtask

    task automatic wait_seeded(output int c);
        int k = 0;
        while (rng_if.seeded !== 1'b1 && k < 400) begin
            tick();
            k++;
        end
        c = cyc;
    endtask

    // Scoreboard consumer: every finish must match the oldest expected word
    initial forever begin
        @(negedge clk);
        if (rng_if.rng_finish === 1'b1) begin
            fin_q.push_back(cyc);
            chk("fin_expected", 96'(exp_q.size() != 0), 96'd1);
            if (exp_q.size() != 0)
                chk("rng_data", rng_if.rng_data, exp_q.pop_front());
        end
    end

    initial begin
        int s, e, c, prev, n;
        logic [79:0] k1, iv1, k2;

        rng_if.seed_load = 1'b0;
        rng_if.seed_key  = '0;
        rng_if.seed_iv   = '0;
        rng_if.rng_start = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_finish", 96'(rng_if.rng_finish), 96'd0);
        chk("rst_data",   rng_if.rng_data, 96'd0);
        chk("rst_seeded", 96'(rng_if.seeded), 96'd0);
        chk("rst_busy",   96'(rng_if.busy), 96'd0);
        rst_b = 1'b1;
        tick();

        // Start before seeding is held until warm-up completes; third start dropped
        pulse_start(e);
        repeat (30) tick();
        chk("unseeded_no_fin", 96'(fin_q.size()), 96'd0);
        do_seed(80'h0, 80'h0, s);
        exp_q.push_back(next_word());
        tick();
        chk("warm_busy", 96'(rng_if.busy), 96'd1);
        wait_seeded(c);
        chk("seeded_time", 96'(c), 96'(s + WARM));
        tick();
        pulse_start(e);
        exp_q.push_back(next_word());
        tick();
        pulse_start(e);
        wait_fin("q_fin0", 0, c);
        chk("q_fin0_time", 96'(c), 96'(s + WARM + 1 + LAT));
        wait_fin("q_fin1", 1, c);
        chk("q_fin1_time", 96'(c), 96'(s + WARM + 1 + 2 * LAT + 1));
        repeat (40) tick();
        chk("third_dropped", 96'(fin_q.size()), 96'd2);

        // Reseed, single-word latency, then back-to-back starts in the finish cycle
        do_seed(80'h0, 80'h0, s);
        wait_seeded(c);
        chk("reseed_time", 96'(c), 96'(s + WARM));
        tick();
        n = fin_q.size();
        pulse_start(e);
        exp_q.push_back(next_word());
        wait_fin("lat", n, c);
        chk("lat_time", 96'(c), 96'(e + LAT));
        prev = c;
        for (int i = 1; i < 4; i++) begin
            pulse_start(e);
            exp_q.push_back(next_word());
            wait_fin("b2b", n + i, c);
            chk("b2b_spacing", 96'(c - prev), 96'(LAT + 1));
            prev = c;
        end

        // Reload five cycles into GEN: aborted word is dropped, fresh word follows warm-up
        k1  = {16'($urandom), $urandom, $urandom};
        iv1 = {16'($urandom), $urandom, $urandom};
        n = fin_q.size();
        pulse_start(e);
        exp_q.push_back(next_word());
        repeat (4) tick();
        do_seed(k1, iv1, s);
        chk("abort_at_gen5", 96'(s - e), 96'd5);
        exp_q.delete();
        exp_q.push_back(next_word());
        wait_fin("abort", n, c);
        chk("abort_fin_time", 96'(c), 96'(s + WARM + 1 + LAT));

        // Asynchronous reset in the middle of warm-up
        k2 = 80'hC0FFEE_0123_4567_89AB;
        do_seed(k2, ~k2, s);
        repeat (50) tick();
        #2;
        rst_b = 1'b0;
        #1;
        chk("arst_finish", 96'(rng_if.rng_finish), 96'd0);
        chk("arst_data",   rng_if.rng_data, 96'd0);
        chk("arst_seeded", 96'(rng_if.seeded), 96'd0);
        chk("arst_busy",   96'(rng_if.busy), 96'd0);
        tick();
        tick();
        rst_b = 1'b1;
        exp_q.delete();
        tick();
        n = fin_q.size();
        pulse_start(e);
        repeat (200) tick();
        chk("arst_no_fin", 96'(fin_q.size()), 96'(n));
        do_seed(k2, iv1, s);
        exp_q.push_back(next_word());
        wait_fin("post_rst", n, c);
        chk("post_rst_time", 96'(c), 96'(s + WARM + 1 + LAT));

        repeat (30) tick();
        chk("sb_empty", 96'(exp_q.size()), 96'd0);
        chk("fin_total", 96'(fin_q.size()), 96'(n + 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
